maple_tx_seq: RTL and testbench
===============================

MAPLE_TX_SEQ -- requirements
Module: maple_tx_seq

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, giving clocks per tick (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have cmd_valid/cmd_ready, in/out, 1 each, frame-command handshake.
REQ-005 SHALL have cmd_len, input, 8, payload byte count minus one (1..256 bytes).
REQ-006 SHALL have cmd_csum, input, 1, which appends an XOR checksum byte when set.
REQ-007 SHALL have src_data, in, 8; src_valid, in, 1; src_ready, out, 1: the payload byte stream.
REQ-008 SHALL have abort, input, 1, a request to terminate the current frame.
REQ-009 SHALL have ctrl_cs, out, 1; ctrl_we, out, 1; ctrl_wdata, out, 8; ctrl_rdata, in, 8: the transmitter control register port.
REQ-010 SHALL have fifo_data, out, 8; fifo_avail, out, 1; fifo_consume, in, 1: the transmitter byte feed.
REQ-011 SHALL have tick, out, 1, the transmitter phase strobe.
REQ-012 SHALL have busy, out, 1; done, out, 1 (pulse); err, out, 1, valid while done is high.

Function
REQ-013 tick SHALL pulse for 1 clock every TICK_DIV clocks, free-running, counter reset to 0.
REQ-014 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, cmd_len, cmd_csum and a cleared xor accumulator SHALL be latched and the FSM SHALL enter START_WR.
REQ-015 START_WR SHALL drive ctrl_cs=1, ctrl_we=1, ctrl_wdata=8'h01 for exactly one clock, then go to DATA.
REQ-016 DATA SHALL drive fifo_data=src_data, fifo_avail=src_valid, src_ready=fifo_consume; each consume SHALL xor the byte into the accumulator and decrement the remaining count.
REQ-017 On consuming the final payload byte, DATA SHALL go to CSUM if cmd_csum is set, otherwise to DRAIN.
REQ-018 CSUM SHALL drive fifo_data=accumulator, fifo_avail=1 until fifo_consume, then go to DRAIN.
REQ-019 DRAIN SHALL wait 32 ticks after the last consume plus one clock, then go to END_WR; if no byte was ever consumed, it SHALL go to END_WR immediately.
REQ-020 END_WR SHALL write 8'h02 for one clock (as REQ-015), then go to END_WAIT.
REQ-021 END_WAIT SHALL assert ctrl_cs=1, ctrl_we=0 every clock and go to DONE in the first clock in which ctrl_rdata[2]=0.
REQ-022 DONE SHALL assert done=1 for one clock and return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-023 When ctrl_cs is not explicitly driven, ctrl_cs, ctrl_we, fifo_avail and src_ready SHALL be 0 and ctrl_wdata SHALL be 8'h00.
REQ-024 abort SHALL be ignored in IDLE, DRAIN, END_WR, END_WAIT and DONE.
REQ-025 abort in START_WR SHALL let the write complete, then go to DRAIN.
REQ-026 abort in DATA or CSUM SHALL go to DRAIN next clock; a byte consumed in the same clock counts as sent; remaining source bytes SHALL NOT be consumed.
REQ-027 err SHALL equal 1 at done if an abort was accepted during the frame, else 0.
REQ-028 cmd_valid while busy SHALL be held off; the command SHALL NOT be lost.

Reset
REQ-029 On rst_n=0, the FSM SHALL be IDLE and counters and accumulator 0; outputs SHALL be cmd_ready=1, busy=0, done=0, err=0, tick=0, all control/feed outputs 0.
REQ-030 Reset mid-frame SHALL abandon the frame without writing an end command.

Structure
REQ-031 Package maple_pkg SHALL hold the state enum, CTRL_START=8'h01, CTRL_END=8'h02 and status bit indices (START=0, END=1, OE=2).
REQ-032 The tick prescaler SHALL be the sub-module maple_tick_gen.

Verification
REQ-033 Verify len=3 (4 bytes A5,5A,FF,00), csum=1: bytes are consumed in order, the fifth byte is 8'h00, 8'h01/8'h02 are each written once, and done=1 with err=0.
REQ-034 Verify len=0, csum=0, byte 8'h3C: exactly one consume occurs, DRAIN lasts 32*TICK_DIV+1 clocks, and END_WR follows.
REQ-035 Verify abort asserted on the 2nd consume of an 8-byte frame: src_ready stays 0 afterward, END_WR follows the drain, and done has err=1.
REQ-036 Verify src_valid gaps of 5 clocks: fifo_avail follows src_valid and the checksum stays correct.
REQ-037 Verify rst_n dropped mid-DATA, then frame re-issued: outputs reach reset values asynchronously and the new frame completes normally.
REQ-038 Verify TICK_DIV=4: tick period is 4 clocks with width 1 clock, and the prescaler runs during IDLE.

Source files
------------

// File: rtl/maple_pkg.sv
// Shared types and constants for the maple frame transmit sequencer.
package maple_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_WR,
    S_DATA,
    S_CSUM,
    S_DRAIN,
    S_END_WR,
    S_END_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] CTRL_START = 8'h01;
  localparam logic [7:0] CTRL_END   = 8'h02;

  localparam int ST_START = 0;
  localparam int ST_END   = 1;
  localparam int ST_OE    = 2;

  localparam int DRAIN_TICKS = 32;

  // Drain time in clocks: a fixed number of tick periods plus one clock.
  function automatic int drain_clks(input int tick_div);
    return DRAIN_TICKS * tick_div + 1;
  endfunction

endpackage

// File: rtl/maple_tick_gen.sv
// Free-running prescaler: one-clock strobe every TICK_DIV clocks.
module maple_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  logic [7:0] r_cnt;
  logic       r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= 8'd0;
      r_tick <= 1'b0;
    end else if (r_cnt == 8'(TICK_DIV - 1)) begin
      r_cnt  <= 8'd0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 8'd1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/maple_tx_seq.sv
// Frame sequencer: start write, payload feed with optional XOR checksum,
// timed drain, end write and completion poll on the transmitter status.
module maple_tx_seq
  import maple_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_len,
  input  logic       cmd_csum,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  input  logic       abort,
  output logic       ctrl_cs,
  output logic       ctrl_we,
  output logic [7:0] ctrl_wdata,
  input  logic [7:0] ctrl_rdata,
  output logic [7:0] fifo_data,
  output logic       fifo_avail,
  input  logic       fifo_consume,
  output logic       tick,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [12:0] DRAIN_LOAD = 13'(drain_clks(TICK_DIV) - 1);

  state_t      r_state;
  logic [7:0]  r_rem;
  logic [7:0]  r_acc;
  logic        r_csum;
  logic        r_any;
  logic        r_err;
  logic [12:0] r_drain;

  logic w_take;
  logic w_oe;
  logic w_unused_rdata;

  assign w_take         = (r_state == S_DATA) && src_valid && fifo_consume;
  assign w_oe           = ctrl_rdata[ST_OE];
  assign w_unused_rdata = ^{ctrl_rdata[7:3], ctrl_rdata[ST_END], ctrl_rdata[ST_START]};

  maple_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= 8'd0;
      r_acc   <= 8'd0;
      r_csum  <= 1'b0;
      r_any   <= 1'b0;
      r_err   <= 1'b0;
      r_drain <= 13'd0;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_rem   <= cmd_len;
          r_csum  <= cmd_csum;
          r_acc   <= 8'd0;
          r_any   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_START_WR;
        end
        S_START_WR: begin
          r_drain <= DRAIN_LOAD;
          if (abort) begin
            r_err   <= 1'b1;
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          r_drain <= DRAIN_LOAD;
          if (w_take) begin
            r_acc <= r_acc ^ src_data;
            r_rem <= r_rem - 8'd1;
            r_any <= 1'b1;
          end
          if (abort) begin
            r_err   <= 1'b1;
            r_state <= S_DRAIN;
          end else if (w_take && r_rem == 8'd0) begin
            r_state <= r_csum ? S_CSUM : S_DRAIN;
          end
        end
        S_CSUM: begin
          r_drain <= DRAIN_LOAD;
          if (fifo_consume) r_any <= 1'b1;
          if (abort) r_err <= 1'b1;
          if (abort || fifo_consume) r_state <= S_DRAIN;
        end
        // Drain is counted in clocks so its length is independent of tick phase.
        S_DRAIN: begin
          if (!r_any || r_drain == 13'd0) r_state <= S_END_WR;
          else r_drain <= r_drain - 13'd1;
        end
        S_END_WR:   r_state <= S_END_WAIT;
        S_END_WAIT: if (!w_oe) r_state <= S_DONE;
        S_DONE:     r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    ctrl_cs    = 1'b0;
    ctrl_we    = 1'b0;
    ctrl_wdata = 8'h00;
    fifo_data  = 8'h00;
    fifo_avail = 1'b0;
    src_ready  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_START_WR: begin
        ctrl_cs    = 1'b1;
        ctrl_we    = 1'b1;
        ctrl_wdata = CTRL_START;
      end
      S_DATA: begin
        fifo_data  = src_data;
        fifo_avail = src_valid;
        src_ready  = fifo_consume;
      end
      S_CSUM: begin
        fifo_data  = r_acc;
        fifo_avail = 1'b1;
      end
      S_END_WR: begin
        ctrl_cs    = 1'b1;
        ctrl_we    = 1'b1;
        ctrl_wdata = CTRL_END;
      end
      S_END_WAIT: ctrl_cs = 1'b1;
      S_DONE: begin
        done = 1'b1;
        err  = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maple_tx_seq.sv
// Directed bench for maple_tx_seq with TICK_DIV=4.
module tb_maple_tx_seq;

  localparam int TD = 4;
  localparam int DRAIN_EXP = 32 * TD + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid, cmd_ready, cmd_csum;
  logic [7:0] cmd_len;
  logic [7:0] src_data;
  logic       src_valid, src_ready, abort;
  logic       ctrl_cs, ctrl_we;
  logic [7:0] ctrl_wdata, ctrl_rdata, fifo_data;
  logic       fifo_avail, fifo_consume, tick, busy, done, err;

  always #5 clk = ~clk;

  maple_tx_seq #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_csum(cmd_csum),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready), .abort(abort),
    .ctrl_cs(ctrl_cs), .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
    .fifo_data(fifo_data), .fifo_avail(fifo_avail), .fifo_consume(fifo_consume),
    .tick(tick), .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scenario inputs
  logic [7:0] f_bytes [0:15];
  int f_n, f_gap, f_abort_at, f_stop_at;

  // Observations of one frame
  logic [7:0] o_bytes [0:15];
  logic [7:0] o_csum_byte;
  logic       o_err;
  int o_pay, o_csum_cnt, o_start, o_end, o_rd, o_done, o_drain;
  int o_avail_bad, o_sr_bad, o_rdy_bad;

  task automatic run_frame(input logic [7:0] len, input logic csum);
    int cyc = 0, last_cons = 0, gap_left = 0, oe_left = 0;
    bit sent = 0, data_phase = 0, aborted = 0;
    o_pay = 0; o_csum_cnt = 0; o_start = 0; o_end = 0; o_rd = 0; o_done = 0;
    o_drain = -1; o_avail_bad = 0; o_sr_bad = 0; o_rdy_bad = 0;
    o_csum_byte = 8'hxx; o_err = 1'bx;
    for (int i = 0; i < 16; i++) o_bytes[i] = 8'hxx;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (abort) begin
        abort   = 1'b0;
        aborted = 1;
      end
      cmd_valid    = !sent;
      cmd_len      = len;
      cmd_csum     = csum;
      src_valid    = (o_pay < f_n) && (gap_left == 0);
      src_data     = f_bytes[o_pay & 15];
      fifo_consume = 1'b1;
      ctrl_rdata   = (oe_left > 0) ? 8'h04 : 8'h03;
      if (oe_left > 0) oe_left--;
      if (gap_left > 0) gap_left--;
      #1;
      if (cmd_valid && cmd_ready) sent = 1;
      if (cmd_ready && busy) o_rdy_bad++;
      if (aborted && src_ready) o_sr_bad++;
      if (data_phase && fifo_avail !== src_valid) o_avail_bad++;
      if (data_phase && !aborted && f_abort_at == o_pay + 1 && fifo_avail) abort = 1'b1;
      if (src_valid && src_ready) begin
        if (o_pay < 16) o_bytes[o_pay] = fifo_data;
        o_pay++;
        last_cons = cyc;
        gap_left  = f_gap;
        if (o_pay == f_n) data_phase = 0;
      end else if (fifo_avail && fifo_consume) begin
        o_csum_byte = fifo_data;
        o_csum_cnt++;
        last_cons = cyc;
      end
      if (abort) data_phase = 0;
      if (ctrl_cs && ctrl_we && ctrl_wdata == 8'h01) begin
        o_start++;
        data_phase = 1;
      end
      if (ctrl_cs && ctrl_we && ctrl_wdata == 8'h02) begin
        o_end++;
        oe_left = 3;
        o_drain = cyc - last_cons - 1;
      end
      if (ctrl_cs && !ctrl_we) o_rd++;
      if (done) begin
        o_done++;
        o_err = err;
        break;
      end
      if (f_stop_at > 0 && o_pay == f_stop_at) break;
    end
    cmd_valid = 1'b0; src_valid = 1'b0; fifo_consume = 1'b0; abort = 1'b0; ctrl_rdata = 8'h00;
  endtask

  task automatic test_reset();
    logic [24:0] got;
    #23;
    got = {cmd_ready, busy, done, err, tick, ctrl_cs, ctrl_we, ctrl_wdata, fifo_avail, src_ready, fifo_data};
    n_cmp++;
    if (got !== 25'h1000000) begin
      n_bad++;
      $display("FAIL reset_outputs got %h expected %h", got, 25'h1000000);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_tick();
    int first = 0, second = 0, highs = 0, adjacent = 0, busy_seen = 0;
    logic prev = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (tick) begin
        highs++;
        if (prev) adjacent++;
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
      if (busy) busy_seen++;
      prev = tick;
    end
    n_cmp++; if (first !== 4) begin n_bad++; $display("FAIL tick_first got %0d expected 4", first); end
    n_cmp++; if (second - first !== TD) begin n_bad++; $display("FAIL tick_period got %0d expected %0d", second - first, TD); end
    n_cmp++; if (highs !== 3) begin n_bad++; $display("FAIL tick_count got %0d expected 3", highs); end
    n_cmp++; if (adjacent !== 0) begin n_bad++; $display("FAIL tick_width got %0d wide pulses expected 0", adjacent); end
    n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL tick_idle_busy got %0d expected 0", busy_seen); end
  endtask

  task automatic test_csum_frame();
    logic [7:0] exp_b [0:3];
    exp_b = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) f_bytes[i] = exp_b[i];
    f_n = 4; f_gap = 0; f_abort_at = 0; f_stop_at = 0;
    run_frame(8'd3, 1'b1);
    n_cmp++; if (o_pay !== 4) begin n_bad++; $display("FAIL csum_payload_count got %0d expected 4", o_pay); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (o_bytes[i] !== exp_b[i]) begin n_bad++; $display("FAIL csum_byte%0d got %h expected %h", i, o_bytes[i], exp_b[i]); end
    end
    n_cmp++; if (o_csum_cnt !== 1) begin n_bad++; $display("FAIL csum_count got %0d expected 1", o_csum_cnt); end
    n_cmp++; if (o_csum_byte !== 8'h00) begin n_bad++; $display("FAIL csum_value got %h expected 00", o_csum_byte); end
    n_cmp++; if (o_start !== 1) begin n_bad++; $display("FAIL csum_start_writes got %0d expected 1", o_start); end
    n_cmp++; if (o_end !== 1) begin n_bad++; $display("FAIL csum_end_writes got %0d expected 1", o_end); end
    n_cmp++; if (o_rd !== 4) begin n_bad++; $display("FAIL csum_end_wait_clocks got %0d expected 4", o_rd); end
    n_cmp++; if (o_done !== 1) begin n_bad++; $display("FAIL csum_done got %0d expected 1", o_done); end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL csum_err got %b expected 0", o_err); end
    n_cmp++; if (o_rdy_bad !== 0) begin n_bad++; $display("FAIL csum_cmd_holdoff got %0d expected 0", o_rdy_bad); end
  endtask

  task automatic test_single_byte();
    f_bytes[0] = 8'h3C;
    f_n = 1; f_gap = 0; f_abort_at = 0; f_stop_at = 0;
    run_frame(8'd0, 1'b0);
    n_cmp++; if (o_pay !== 1) begin n_bad++; $display("FAIL single_consumes got %0d expected 1", o_pay); end
    n_cmp++; if (o_bytes[0] !== 8'h3C) begin n_bad++; $display("FAIL single_byte got %h expected 3c", o_bytes[0]); end
    n_cmp++; if (o_csum_cnt !== 0) begin n_bad++; $display("FAIL single_no_csum got %0d expected 0", o_csum_cnt); end
    n_cmp++; if (o_drain !== DRAIN_EXP) begin n_bad++; $display("FAIL single_drain got %0d expected %0d", o_drain, DRAIN_EXP); end
    n_cmp++; if (o_end !== 1) begin n_bad++; $display("FAIL single_end_writes got %0d expected 1", o_end); end
    n_cmp++; if (o_done !== 1 || o_err !== 1'b0) begin n_bad++; $display("FAIL single_done got %0d/%b expected 1/0", o_done, o_err); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) f_bytes[i] = 8'((i + 1) * 8'h11);
    f_n = 8; f_gap = 0; f_abort_at = 2; f_stop_at = 0;
    run_frame(8'd7, 1'b1);
    n_cmp++; if (o_pay !== 2) begin n_bad++; $display("FAIL abort_consumes got %0d expected 2", o_pay); end
    n_cmp++; if (o_bytes[1] !== 8'h22) begin n_bad++; $display("FAIL abort_last_byte got %h expected 22", o_bytes[1]); end
    n_cmp++; if (o_csum_cnt !== 0) begin n_bad++; $display("FAIL abort_csum_skipped got %0d expected 0", o_csum_cnt); end
    n_cmp++; if (o_sr_bad !== 0) begin n_bad++; $display("FAIL abort_src_ready got %0d high clocks expected 0", o_sr_bad); end
    n_cmp++; if (o_end !== 1) begin n_bad++; $display("FAIL abort_end_writes got %0d expected 1", o_end); end
    n_cmp++; if (o_drain !== DRAIN_EXP) begin n_bad++; $display("FAIL abort_drain got %0d expected %0d", o_drain, DRAIN_EXP); end
    n_cmp++; if (o_done !== 1 || o_err !== 1'b1) begin n_bad++; $display("FAIL abort_done got %0d/%b expected 1/1", o_done, o_err); end
  endtask

  task automatic test_gaps();
    f_bytes[0] = 8'h12; f_bytes[1] = 8'h34; f_bytes[2] = 8'h56;
    f_n = 3; f_gap = 5; f_abort_at = 0; f_stop_at = 0;
    run_frame(8'd2, 1'b1);
    n_cmp++; if (o_avail_bad !== 0) begin n_bad++; $display("FAIL gap_avail_follow got %0d bad clocks expected 0", o_avail_bad); end
    n_cmp++; if (o_pay !== 3) begin n_bad++; $display("FAIL gap_consumes got %0d expected 3", o_pay); end
    n_cmp++; if (o_csum_byte !== 8'h70) begin n_bad++; $display("FAIL gap_csum got %h expected 70", o_csum_byte); end
    n_cmp++; if (o_done !== 1 || o_err !== 1'b0) begin n_bad++; $display("FAIL gap_done got %0d/%b expected 1/0", o_done, o_err); end
  endtask

  task automatic test_reset_mid();
    logic [24:0] got;
    for (int i = 0; i < 8; i++) f_bytes[i] = 8'(i + 1);
    f_n = 8; f_gap = 0; f_abort_at = 0; f_stop_at = 2;
    run_frame(8'd7, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got %b expected 1", busy); end
    src_valid = 1'b1; fifo_consume = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    got = {cmd_ready, busy, done, err, tick, ctrl_cs, ctrl_we, ctrl_wdata, fifo_avail, src_ready, fifo_data};
    n_cmp++;
    if (got !== 25'h1000000) begin
      n_bad++;
      $display("FAIL rstmid_outputs got %h expected %h", got, 25'h1000000);
    end
    n_cmp++; if (o_end !== 0) begin n_bad++; $display("FAIL rstmid_no_end got %0d expected 0", o_end); end
    src_valid = 1'b0; fifo_consume = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    f_bytes[0] = 8'h0F; f_bytes[1] = 8'hF0;
    f_n = 2; f_stop_at = 0;
    run_frame(8'd1, 1'b1);
    n_cmp++; if (o_start !== 1 || o_end !== 1) begin n_bad++; $display("FAIL rstmid_refr_writes got %0d/%0d expected 1/1", o_start, o_end); end
    n_cmp++; if (o_csum_byte !== 8'hFF) begin n_bad++; $display("FAIL rstmid_refr_csum got %h expected ff", o_csum_byte); end
    n_cmp++; if (o_done !== 1 || o_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_refr_done got %0d/%b expected 1/0", o_done, o_err); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_len = 8'd0; cmd_csum = 1'b0;
    src_data = 8'd0; src_valid = 1'b0; abort = 1'b0;
    ctrl_rdata = 8'h00; fifo_consume = 1'b0;
    test_reset();
    test_tick();
    test_csum_frame();
    test_single_byte();
    test_abort();
    test_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
